mips_alu: RTL and testbench

- Registered 32-bit integer ALU for the multi-cycle MIPS-subset core; instantiated by the instruction decode/execute FSM.
- Operands and a 4-bit operation code are sampled every clock edge. The result and status flags appear one cycle later.
- The FSM programs the op code, latches the operands, waits one "calculate" state, then reads the result and overflow flag.

---
 rtl/mips_alu.sv | 116 +++++++++++
 tb/tb_mips_alu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mips_alu                                                |
// | Purpose  : Registered 32-bit integer ALU with overflow/zero flags. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    localparam int         c_MSB     = WIDTH - 1;
    localparam logic [3:0] c_OP_ADDU = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0100;
    localparam logic [3:0] c_OP_OR   = 4'b0101;
    localparam logic [3:0] c_OP_XOR  = 4'b0110;
    localparam logic [3:0] c_OP_NOR  = 4'b0111;
    localparam logic [3:0] c_OP_SUBU = 4'b1000;
    localparam logic [3:0] c_OP_SUB  = 4'b1001;
    localparam logic [3:0] c_OP_SLTU = 4'b1010;
    localparam logic [3:0] c_OP_SLT  = 4'b1011;
    localparam logic [3:0] c_OP_SLL  = 4'b1100;
    localparam logic [3:0] c_OP_SRL  = 4'b1101;
    localparam logic [3:0] c_OP_SRA  = 4'b1110;
    localparam logic [3:0] c_OP_LUI  = 4'b1111;

    logic [WIDTH-1:0]        w_sum;
    logic [WIDTH:0]          w_diff_ext;
    logic [WIDTH-1:0]        w_diff;
    logic                    w_add_ovf;
    logic                    w_sub_ovf;
    logic                    w_slt;
    logic                    w_sltu;
    logic [4:0]              w_shamt;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]        w_lui;
    logic [WIDTH-1:0]        w_next_result;
    logic                    w_next_overflow;

    logic [WIDTH-1:0]        r_result;
    logic                    r_overflow;
    logic                    r_zero;

    // One extended subtractor serves sub/subu, the borrow for sltu and the sign for slt.
    assign w_sum      = operand_a + operand_b;
    assign w_diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
    assign w_diff     = w_diff_ext[WIDTH-1:0];
    assign w_add_ovf  = (operand_a[c_MSB] == operand_b[c_MSB]) && (w_sum[c_MSB]  != operand_a[c_MSB]);
    assign w_sub_ovf  = (operand_a[c_MSB] != operand_b[c_MSB]) && (w_diff[c_MSB] != operand_a[c_MSB]);
    assign w_sltu     = w_diff_ext[WIDTH];

    // When signs differ the negative operand is the smaller one, so a wrapped difference never matters.
    assign w_slt      = (operand_a[c_MSB] != operand_b[c_MSB]) ? operand_a[c_MSB] : w_diff[c_MSB];

    assign w_shamt    = operand_a[4:0];
    assign w_sra      = $signed(operand_b) >>> w_shamt;
    assign w_lui      = {operand_b[15:0], {(WIDTH-16){1'b0}}};

    always_comb begin
        w_next_result   = '0;
        w_next_overflow = 1'b0;
        case (alu_ctrl)
            c_OP_ADDU: w_next_result = w_sum;
            c_OP_ADD: begin
                w_next_result   = w_sum;
                w_next_overflow = w_add_ovf;
            end
            c_OP_SUBU: w_next_result = w_diff;
            c_OP_SUB: begin
                w_next_result   = w_diff;
                w_next_overflow = w_sub_ovf;
            end
            c_OP_AND:  w_next_result = operand_a & operand_b;
            c_OP_OR:   w_next_result = operand_a | operand_b;
            c_OP_XOR:  w_next_result = operand_a ^ operand_b;
            c_OP_NOR:  w_next_result = ~(operand_a | operand_b);
            c_OP_SLTU: w_next_result = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_SLT:  w_next_result = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_SLL:  w_next_result = operand_b << w_shamt;
            c_OP_SRL:  w_next_result = operand_b >> w_shamt;
            c_OP_SRA:  w_next_result = w_sra;
            c_OP_LUI:  w_next_result = w_lui;
            default: begin
                w_next_result   = '0;
                w_next_overflow = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_result   <= w_next_result;
            r_overflow <= w_next_overflow;
            r_zero     <= (w_next_result == '0);
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_mips_alu                                             |
// | Purpose  : Scoreboard-based self-checking bench for mips_alu.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        overflow;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zr;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    mips_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_ctrl  (alu_ctrl),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] res, input logic ovf, input string name);
        exp_t e;
        e.res  = res;
        e.ovf  = ovf;
        e.zr   = (res == 32'h0);
        e.name = name;
        return e;
    endfunction

    // Reference model built on 64-bit signed arithmetic rather than sign-bit tricks.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      s;
        longint      maxs;
        longint      mins;
        logic [31:0] r;
        logic [4:0]  sh;
        logic        o;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        maxs = 64'sd2147483647;
        mins = -maxs - 64'sd1;
        sh   = a[4:0];
        r    = 32'h0;
        o    = 1'b0;
        case (c)
            4'b0000: r = a + b;
            4'b0001: begin s = sa + sbv; r = s[31:0]; o = (s > maxs) || (s < mins); end
            4'b1000: r = a - b;
            4'b1001: begin s = sa - sbv; r = s[31:0]; o = (s > maxs) || (s < mins); end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1010: r = (a < b) ? 32'd1 : 32'd0;
            4'b1011: r = (sa < sbv) ? 32'd1 : 32'd0;
            4'b1100: r = b << sh;
            4'b1101: r = b >> sh;
            4'b1110: begin s = sbv >>> sh; r = s[31:0]; end
            4'b1111: r = {b[15:0], 16'h0000};
            default: r = 32'h0;
        endcase
        return mk(r, o, $sformatf("op%b", c));
    endfunction

    // Drive one cycle of inputs, queue what must appear after the edge, then move past that edge.
    task automatic issue(input logic rn, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        rst_n     = rn;
        alu_ctrl  = c;
        operand_a = a;
        operand_b = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 4'($urandom), $urandom, $urandom, mk(32'h0, 1'b0, "reset"));
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
        issue(1'b1, 4'b0000, 32'd3, 32'd4, mk(32'd7, 1'b0, "first_addu"));
        e = sb.pop_front();
        n_cmp++;
        if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
            n_err++;
            $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                     e.name, result, overflow, zero, e.res, e.ovf, e.zr);
        end
    endtask

    task automatic test_arith();
        logic [3:0]  c[6];
        logic [31:0] a[6];
        logic [31:0] b[6];
        exp_t        x[6];
        exp_t        e;
        c[0] = 4'b0001; a[0] = 32'h7FFFFFFF; b[0] = 32'h1;        x[0] = mk(32'h80000000, 1'b1, "add_ovf");
        c[1] = 4'b0000; a[1] = 32'h7FFFFFFF; b[1] = 32'h1;        x[1] = mk(32'h80000000, 1'b0, "addu_no_ovf");
        c[2] = 4'b1001; a[2] = 32'h80000000; b[2] = 32'h1;        x[2] = mk(32'h7FFFFFFF, 1'b1, "sub_ovf");
        c[3] = 4'b1001; a[3] = 32'd5;        b[3] = 32'd5;        x[3] = mk(32'h0, 1'b0, "sub_zero");
        c[4] = 4'b1000; a[4] = 32'h80000000; b[4] = 32'h1;        x[4] = mk(32'h7FFFFFFF, 1'b0, "subu_no_ovf");
        c[5] = 4'b0001; a[5] = 32'h80000000; b[5] = 32'h80000000; x[5] = mk(32'h0, 1'b1, "add_neg_ovf");
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, c[i], a[i], b[i], x[i]);
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0]  c[4];
        logic [31:0] a[4];
        logic [31:0] b[4];
        exp_t        x[4];
        exp_t        e;
        c[0] = 4'b1011; a[0] = 32'hFFFFFFFF; b[0] = 32'h1;        x[0] = mk(32'h1, 1'b0, "slt_neg");
        c[1] = 4'b1010; a[1] = 32'hFFFFFFFF; b[1] = 32'h1;        x[1] = mk(32'h0, 1'b0, "sltu_big");
        c[2] = 4'b1011; a[2] = 32'h80000000; b[2] = 32'h7FFFFFFF; x[2] = mk(32'h1, 1'b0, "slt_wrap");
        c[3] = 4'b1011; a[3] = 32'h7FFFFFFF; b[3] = 32'h80000000; x[3] = mk(32'h0, 1'b0, "slt_wrap_rev");
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, c[i], a[i], b[i], x[i]);
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  c[12];
        logic [31:0] a[12];
        logic [31:0] b[12];
        exp_t        x[12];
        exp_t        e;
        c[0]  = 4'b0100; a[0]  = 32'hF0F0F0F0; b[0]  = 32'h0FF00FF0; x[0]  = mk(32'h00F000F0, 1'b0, "and");
        c[1]  = 4'b0101; a[1]  = 32'hF0F0F0F0; b[1]  = 32'h0FF00FF0; x[1]  = mk(32'hFFF0FFF0, 1'b0, "or");
        c[2]  = 4'b0110; a[2]  = 32'hF0F0F0F0; b[2]  = 32'h0FF00FF0; x[2]  = mk(32'hFF00FF00, 1'b0, "xor");
        c[3]  = 4'b0111; a[3]  = 32'hF0F0F0F0; b[3]  = 32'h0FF00FF0; x[3]  = mk(32'h000F000F, 1'b0, "nor");
        c[4]  = 4'b1100; a[4]  = 32'd4;        b[4]  = 32'h80000010; x[4]  = mk(32'h00000100, 1'b0, "sll");
        c[5]  = 4'b1101; a[5]  = 32'd4;        b[5]  = 32'h80000010; x[5]  = mk(32'h08000001, 1'b0, "srl");
        c[6]  = 4'b1110; a[6]  = 32'd4;        b[6]  = 32'h80000010; x[6]  = mk(32'hF8000001, 1'b0, "sra");
        c[7]  = 4'b1111; a[7]  = 32'hDEADBEEF; b[7]  = 32'h00001234; x[7]  = mk(32'h12340000, 1'b0, "lui");
        c[8]  = 4'b1110; a[8]  = 32'hFFFFFFE0; b[8]  = 32'h80000010; x[8]  = mk(32'h80000010, 1'b0, "sra_by0_hi_ignored");
        c[9]  = 4'b1100; a[9]  = 32'h0000003F; b[9]  = 32'hFFFFFFFF; x[9]  = mk(32'h80000000, 1'b0, "sll_by31");
        c[10] = 4'b0010; a[10] = 32'h12345678; b[10] = 32'h9ABCDEF0; x[10] = mk(32'h0, 1'b0, "reserved_0010");
        c[11] = 4'b0011; a[11] = 32'h7FFFFFFF; b[11] = 32'h1;        x[11] = mk(32'h0, 1'b0, "reserved_0011");
        for (int i = 0; i < 12; i++) begin
            issue(1'b1, c[i], a[i], b[i], x[i]);
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic        rn[4];
        logic [3:0]  c[4];
        logic [31:0] a[4];
        logic [31:0] b[4];
        exp_t        x[4];
        exp_t        e;
        rn[0] = 1'b1; c[0] = 4'b0001; a[0] = 32'h7FFFFFFF; b[0] = 32'h1; x[0] = mk(32'h80000000, 1'b1, "pre_reset_add");
        rn[1] = 1'b0; c[1] = 4'b0001; a[1] = 32'h7FFFFFFF; b[1] = 32'h5; x[1] = mk(32'h0, 1'b0, "mid_reset");
        rn[2] = 1'b0; c[2] = 4'b0101; a[2] = 32'hFFFF0000; b[2] = 32'h1; x[2] = mk(32'h0, 1'b0, "mid_reset_hold");
        rn[3] = 1'b1; c[3] = 4'b0110; a[3] = 32'hA5A5A5A5; b[3] = 32'h0; x[3] = mk(32'hA5A5A5A5, 1'b0, "post_reset_xor");
        for (int i = 0; i < 4; i++) begin
            issue(rn[i], c[i], a[i], b[i], x[i]);
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL %s: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] corner[5];
        exp_t        e;
        corner[0] = 32'h0;
        corner[1] = 32'hFFFFFFFF;
        corner[2] = 32'h7FFFFFFF;
        corner[3] = 32'h80000000;
        corner[4] = 32'h1;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            issue(1'b1, c, a, b, model(c, a, b));
            e = sb.pop_front();
            n_cmp++;
            if (result !== e.res || overflow !== e.ovf || zero !== e.zr) begin
                n_err++;
                $display("FAIL b2b_%s a=%h b=%h: got res=%h ovf=%b zero=%b, expected res=%h ovf=%b zero=%b",
                         e.name, a, b, result, overflow, zero, e.res, e.ovf, e.zr);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        alu_ctrl  = 4'b0000;
        operand_a = 32'h0;
        operand_b = 32'h0;
        test_reset();
        test_arith();
        test_compare();
        test_logic_shift();
        test_mid_reset();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
